// File: rtl/wdt_pkg.sv
// Shared types for the windowed watchdog: controller states and fire-cause codes.
package wdt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIRE = 2'd2
  } state_t;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b01;
  localparam logic [1:0] CAUSE_EARLY   = 2'b10;

endpackage

// File: rtl/wdt_pulse_gen.sv
// Fixed-width pulse stretcher: a start strobe yields a registered pulse of
// exactly RST_PULSE cycles; done marks the final cycle of that pulse.
module wdt_pulse_gen #(
  parameter int RST_PULSE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic pulse,
  output logic done
);

  localparam int PW = $clog2(RST_PULSE + 1);

  logic [PW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      pulse <= 1'b0;
    end else if (start) begin
      cnt   <= PW'(RST_PULSE);
      pulse <= 1'b1;
    end else if (cnt != '0) begin
      cnt   <= cnt - PW'(1);
      pulse <= (cnt > PW'(1));
    end
  end

  assign done = (cnt == PW'(1));

endmodule

// File: rtl/wdt_window_ctrl.sv
// Windowed watchdog controller: counts while enabled, fires a stretched reset on
// timeout or early kick, raises a sticky early-warning level, and reports cause.
module wdt_window_ctrl
  import wdt_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int RST_PULSE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             cfg_we,
  input  logic [CNT_W-1:0] cfg_timeout,
  input  logic [CNT_W-1:0] cfg_window,
  input  logic [CNT_W-1:0] cfg_warn,
  input  logic             kick,
  output logic [CNT_W-1:0] count,
  output logic             running,
  output logic             warn_irq,
  output logic             wdt_reset,
  output logic [1:0]       cause
);

  state_t           state, state_nx;
  logic [CNT_W-1:0] thr_timeout, thr_window, thr_warn;
  logic [CNT_W-1:0] count_nx;
  logic             warn_nx;
  logic [1:0]       cause_nx;
  logic             fire_start, pulse_done;

  logic cfg_ok, early_kick, legal_kick, timeout_hit, warn_hit;

  // A write with a zero timeout or a window past the timeout is dropped whole.
  assign cfg_ok      = (state == IDLE) && cfg_we && (cfg_timeout != '0) &&
                       (cfg_window <= cfg_timeout);
  assign early_kick  = kick && (thr_window != '0) && (count < thr_window);
  assign legal_kick  = kick && !early_kick;
  assign timeout_hit = (count == thr_timeout);
  assign warn_hit    = (thr_warn != '0) && (count == thr_warn);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_nx   = state;
    count_nx   = count;
    warn_nx    = warn_irq;
    cause_nx   = cause;
    fire_start = 1'b0;
    unique case (state)
      IDLE: begin
        count_nx = '0;
        if (cfg_ok) cause_nx = CAUSE_NONE;
        if (enable) state_nx = RUN;
      end
      RUN: begin
        // Priority: early kick, legal kick, timeout, enable low.
        if (early_kick) begin
          state_nx   = FIRE;
          cause_nx   = CAUSE_EARLY;
          fire_start = 1'b1;
          warn_nx    = warn_irq | warn_hit;
        end else if (legal_kick) begin
          count_nx = '0;
          warn_nx  = 1'b0;
        end else if (timeout_hit) begin
          state_nx   = FIRE;
          cause_nx   = CAUSE_TIMEOUT;
          fire_start = 1'b1;
          warn_nx    = warn_irq | warn_hit;
        end else if (!enable) begin
          state_nx = IDLE;
          count_nx = '0;
          warn_nx  = 1'b0;
        end else begin
          count_nx = count + CNT_W'(1);
          warn_nx  = warn_irq | warn_hit;
        end
      end
      FIRE: begin
        if (pulse_done) begin
          state_nx = IDLE;
          count_nx = '0;
          warn_nx  = 1'b0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      running     <= 1'b0;
      warn_irq    <= 1'b0;
      cause       <= CAUSE_NONE;
      thr_timeout <= '1;
      thr_window  <= '0;
      thr_warn    <= '0;
    end else begin
      state    <= state_nx;
      count    <= count_nx;
      running  <= (state_nx == RUN);
      warn_irq <= warn_nx;
      cause    <= cause_nx;
      if (cfg_ok) begin
        thr_timeout <= cfg_timeout;
        thr_window  <= cfg_window;
        thr_warn    <= cfg_warn;
      end
    end
  end

  wdt_pulse_gen #(
    .RST_PULSE(RST_PULSE)
  ) u_pulse (
    .clk  (clk),
    .rst  (rst),
    .start(fire_start),
    .pulse(wdt_reset),
    .done (pulse_done)
  );

endmodule

// File: tb/tb_wdt_window_ctrl.sv
// Scenario bench for wdt_window_ctrl (CNT_W=8, RST_PULSE=4); expected snapshots
// {count, running, warn_irq, wdt_reset, cause} are queued per driven cycle.
module tb_wdt_window_ctrl;

  logic       clk = 1'b0;
  logic       rst, enable, cfg_we, kick;
  logic [7:0] cfg_timeout, cfg_window, cfg_warn;
  logic [7:0] count;
  logic       running, warn_irq, wdt_reset;
  logic [1:0] cause;

  typedef logic [12:0] snap_t;
  snap_t exp_q[$];
  int    total = 0;
  int    bad   = 0;

  wdt_window_ctrl #(.CNT_W(8), .RST_PULSE(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .cfg_we     (cfg_we),
    .cfg_timeout(cfg_timeout),
    .cfg_window (cfg_window),
    .cfg_warn   (cfg_warn),
    .kick       (kick),
    .count      (count),
    .running    (running),
    .warn_irq   (warn_irq),
    .wdt_reset  (wdt_reset),
    .cause      (cause)
  );

  always #5 clk = ~clk;

  function automatic snap_t pk(int c, bit r, bit w, bit p, int ca);
    return {8'(c), r, w, p, 2'(ca)};
  endfunction

  function automatic snap_t obs();
    return {count, running, warn_irq, wdt_reset, cause};
  endfunction

  task automatic apply_cfg(int t, int w, int wr);
    cfg_timeout = 8'(t);
    cfg_window  = 8'(w);
    cfg_warn    = 8'(wr);
    cfg_we      = 1'b1;
    @(posedge clk); #1;
    cfg_we      = 1'b0;
  endtask

  task automatic test_reset();
    snap_t got, ex;
    rst = 1'b1; enable = 1'b0; cfg_we = 1'b0; kick = 1'b0;
    cfg_timeout = '0; cfg_window = '0; cfg_warn = '0;
    exp_q.push_back(pk(0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    ex = exp_q.pop_front(); got = obs(); total++;
    if (got !== ex) begin bad++; $display("FAIL reset_held got=%h exp=%h", got, ex); end
    rst = 1'b0;
    exp_q.push_back(pk(0, 0, 0, 0, 0));
    @(posedge clk); #1;
    ex = exp_q.pop_front(); got = obs(); total++;
    if (got !== ex) begin bad++; $display("FAIL reset_release got=%h exp=%h", got, ex); end
  endtask

  task automatic test_timeout();
    snap_t got, ex;
    apply_cfg(10, 0, 0);
    for (int e = 1; e <= 16; e++) begin
      enable = (e <= 12);
      if (e <= 11)      exp_q.push_back(pk(e - 1, 1, 0, 0, 0));
      else if (e <= 15) exp_q.push_back(pk(10, 0, 0, 1, 1));
      else              exp_q.push_back(pk(0, 0, 0, 0, 1));
      @(posedge clk); #1;
      ex = exp_q.pop_front(); got = obs(); total++;
      if (got !== ex) begin bad++; $display("FAIL timeout cyc=%0d got=%h exp=%h", e, got, ex); end
    end
  endtask

  task automatic test_window();
    snap_t got, ex;
    apply_cfg(10, 4, 8);
    for (int e = 1; e <= 8; e++) begin
      enable = (e <= 4);
      kick   = (e == 4);
      if (e <= 3)      exp_q.push_back(pk(e - 1, 1, 0, 0, 0));
      else if (e <= 7) exp_q.push_back(pk(2, 0, 0, 1, 2));
      else             exp_q.push_back(pk(0, 0, 0, 0, 2));
      @(posedge clk); #1;
      ex = exp_q.pop_front(); got = obs(); total++;
      if (got !== ex) begin bad++; $display("FAIL early_kick cyc=%0d got=%h exp=%h", e, got, ex); end
    end
    for (int e = 1; e <= 8; e++) begin
      enable = (e <= 7);
      kick   = (e == 6);
      if (e <= 5)       exp_q.push_back(pk(e - 1, 1, 0, 0, 2));
      else if (e == 6)  exp_q.push_back(pk(0, 1, 0, 0, 2));
      else if (e == 7)  exp_q.push_back(pk(1, 1, 0, 0, 2));
      else              exp_q.push_back(pk(0, 0, 0, 0, 2));
      @(posedge clk); #1;
      ex = exp_q.pop_front(); got = obs(); total++;
      if (got !== ex) begin bad++; $display("FAIL window_edge_kick cyc=%0d got=%h exp=%h", e, got, ex); end
    end
    kick = 1'b0;
  endtask

  task automatic test_warning();
    snap_t got, ex;
    apply_cfg(10, 0, 8);
    for (int e = 1; e <= 16; e++) begin
      enable = (e <= 12);
      if (e <= 9)       exp_q.push_back(pk(e - 1, 1, 0, 0, 0));
      else if (e <= 11) exp_q.push_back(pk(e - 1, 1, 1, 0, 0));
      else if (e <= 15) exp_q.push_back(pk(10, 0, 1, 1, 1));
      else              exp_q.push_back(pk(0, 0, 0, 0, 1));
      @(posedge clk); #1;
      ex = exp_q.pop_front(); got = obs(); total++;
      if (got !== ex) begin bad++; $display("FAIL warn_fire cyc=%0d got=%h exp=%h", e, got, ex); end
    end
    // Kick at count 9 clears a set warning.
    for (int e = 1; e <= 13; e++) begin
      enable = (e <= 12);
      kick   = (e == 11);
      if (e <= 9)       exp_q.push_back(pk(e - 1, 1, 0, 0, 1));
      else if (e == 10) exp_q.push_back(pk(9, 1, 1, 0, 1));
      else if (e == 11) exp_q.push_back(pk(0, 1, 0, 0, 1));
      else if (e == 12) exp_q.push_back(pk(1, 1, 0, 0, 1));
      else              exp_q.push_back(pk(0, 0, 0, 0, 1));
      @(posedge clk); #1;
      ex = exp_q.pop_front(); got = obs(); total++;
      if (got !== ex) begin bad++; $display("FAIL warn_clear cyc=%0d got=%h exp=%h", e, got, ex); end
    end
    // Kick exactly at the warning count: warning never rises.
    for (int e = 1; e <= 12; e++) begin
      enable = (e <= 11);
      kick   = (e == 10);
      if (e <= 9)       exp_q.push_back(pk(e - 1, 1, 0, 0, 1));
      else if (e == 10) exp_q.push_back(pk(0, 1, 0, 0, 1));
      else if (e == 11) exp_q.push_back(pk(1, 1, 0, 0, 1));
      else              exp_q.push_back(pk(0, 0, 0, 0, 1));
      @(posedge clk); #1;
      ex = exp_q.pop_front(); got = obs(); total++;
      if (got !== ex) begin bad++; $display("FAIL warn_vs_kick cyc=%0d got=%h exp=%h", e, got, ex); end
    end
    kick = 1'b0;
  endtask

  task automatic test_simultaneous();
    snap_t got, ex;
    apply_cfg(10, 4, 0);
    for (int e = 1; e <= 14; e++) begin
      enable = (e <= 13);
      kick   = (e == 12);
      if (e <= 11)      exp_q.push_back(pk(e - 1, 1, 0, 0, 0));
      else if (e == 12) exp_q.push_back(pk(0, 1, 0, 0, 0));
      else if (e == 13) exp_q.push_back(pk(1, 1, 0, 0, 0));
      else              exp_q.push_back(pk(0, 0, 0, 0, 0));
      @(posedge clk); #1;
      ex = exp_q.pop_front(); got = obs(); total++;
      if (got !== ex) begin bad++; $display("FAIL kick_at_timeout cyc=%0d got=%h exp=%h", e, got, ex); end
    end
    kick = 1'b0;
  endtask

  task automatic test_cfg_guard();
    snap_t got, ex;
    // Both writes are illegal; 10/4/0 must remain in force.
    apply_cfg(0, 0, 0);
    apply_cfg(10, 12, 0);
    cfg_timeout = 8'd3; cfg_window = 8'd0; cfg_warn = 8'd0;
    for (int e = 1; e <= 22; e++) begin
      enable = (e <= 18);
      kick   = (e == 7);
      cfg_we = (e == 8);
      if (e <= 6)       exp_q.push_back(pk(e - 1, 1, 0, 0, 0));
      else if (e <= 17) exp_q.push_back(pk(e - 7, 1, 0, 0, 0));
      else if (e <= 21) exp_q.push_back(pk(10, 0, 0, 1, 1));
      else              exp_q.push_back(pk(0, 0, 0, 0, 1));
      @(posedge clk); #1;
      ex = exp_q.pop_front(); got = obs(); total++;
      if (got !== ex) begin bad++; $display("FAIL cfg_guard cyc=%0d got=%h exp=%h", e, got, ex); end
    end
    kick = 1'b0; cfg_we = 1'b0;
    exp_q.push_back(pk(0, 0, 0, 0, 0));
    apply_cfg(10, 0, 0);
    ex = exp_q.pop_front(); got = obs(); total++;
    if (got !== ex) begin bad++; $display("FAIL cfg_clears_cause got=%h exp=%h", got, ex); end
  endtask

  task automatic test_reset_enable();
    snap_t got, ex;
    apply_cfg(10, 0, 0);
    for (int e = 1; e <= 13; e++) begin
      enable = 1'b1;
      if (e <= 11) exp_q.push_back(pk(e - 1, 1, 0, 0, 0));
      else         exp_q.push_back(pk(10, 0, 0, 1, 1));
      @(posedge clk); #1;
      ex = exp_q.pop_front(); got = obs(); total++;
      if (got !== ex) begin bad++; $display("FAIL pre_rst_fire cyc=%0d got=%h exp=%h", e, got, ex); end
    end
    // Second FIRE cycle: asynchronous reset must clear everything without a clock.
    exp_q.push_back(pk(0, 0, 0, 0, 0));
    rst = 1'b1; enable = 1'b0;
    #1;
    ex = exp_q.pop_front(); got = obs(); total++;
    if (got !== ex) begin bad++; $display("FAIL async_rst_fire got=%h exp=%h", got, ex); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    for (int e = 1; e <= 8; e++) begin
      enable = (e <= 6);
      if (e <= 6) exp_q.push_back(pk(e - 1, 1, 0, 0, 0));
      else        exp_q.push_back(pk(0, 0, 0, 0, 0));
      @(posedge clk); #1;
      ex = exp_q.pop_front(); got = obs(); total++;
      if (got !== ex) begin bad++; $display("FAIL enable_drop cyc=%0d got=%h exp=%h", e, got, ex); end
    end
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_window();
    test_warning();
    test_simultaneous();
    test_cfg_guard();
    test_reset_enable();
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL sim_time_limit reached got=running exp=finished");
    $fatal(1, "time limit");
  end

endmodule
